spio_hss_multiplexer_reg_arbiter: RTL and testbench
===================================================

Name: spio_hss_multiplexer_reg_arbiter

Overview:
Shares the HSS multiplexer register bank access port (reg_write / reg_addr / reg_write_data / reg_read_data) between NUM_REQ independent requesters, for example a host SPI bridge and an on-chip diagnostics scanner.
Round-robin arbitration with a req/ack handshake; one register access per grant.
Sits between the requesters and the register bank; it is the only driver of the bank's access port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
REGA_W, `REGA_BITS, register address width
REGD_W, `REGD_BITS, register data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester access request (level)
req_write  in  NUM_REQ  per-requester write flag; 0 = read
req_addr  in  NUM_REQ*REGA_W  packed addresses; requester i uses slice [i*REGA_W +: REGA_W]
req_wdata  in  NUM_REQ*REGD_W  packed write data; same slicing rule
ack  out  NUM_REQ  one-hot completion pulse
rdata  out  REGD_W  read data, valid while any ack bit is high
reg_write  out  1  to register bank
reg_addr  out  REGA_W  to register bank
reg_write_data  out  REGD_W  to register bank
reg_read_data  in  REGD_W  from register bank (combinational on reg_addr)

Behaviour:
- Reset values: ack=0, rdata=0, reg_write=0, reg_addr=0, reg_write_data=0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from rr_ptr+1 upward, modulo NUM_REQ.
  - At the clock edge: latch the winner's write/addr/wdata into reg_addr / reg_write_data and the write flag; store the winner index; set rr_ptr=winner; go to ACCESS.
  - If no req bit is high: stay in IDLE; reg_addr holds its last value.
- ACCESS (exactly 1 cycle):
  - reg_write = latched write flag; reg_addr and reg_write_data stable.
  - At the clock edge: rdata <= reg_read_data. For a write access this is the pre-write value.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - ack[winner]=1, reg_write=0; return to IDLE.
- Latency: request seen in IDLE at edge 0 -> ACCESS cycle 1 -> ack high in cycle 2.
- Throughput: one access per 3 cycles.
- Handshake:
  - The requester's inputs are sampled only at the grant edge. Changing or deasserting them after grant does not affect the transaction; ack is still issued.
  - A requester that wants no further access must have req low at the edge ending its ACK cycle. A req still high there is a new request.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
- reg_write is never high outside ACCESS.
- ack is one-hot or zero.
- rdata holds its value outside ACK.
- Reset asserted mid-transaction: the transaction is abandoned immediately (asynchronous). No ack is produced, and a pending write may or may not have reached the bank.

Optional Feature:
SPIO_HSS_REG_ARB_LOCK_EN:
- Adds input req_lock [NUM_REQ], sampled with the other request fields at the grant edge.
- If the granted access has lock=1, the owner becomes locked. While locked, IDLE grants only the owner; others wait and rr_ptr is unchanged.
- The lock releases after an owner access with lock=0, or when the owner's req is low in IDLE. Either event releases the lock that same cycle, and normal round-robin applies.
- Used for read-modify-write of reg_idso.
- Without the macro: no port, no lock state, pure round-robin.

Decomposition:
- Shared header spio_hss_multiplexer_reg_arbiter.h holds the FSM state encodings (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2).
- REGA_BITS / REGD_BITS remain in the existing common header.
- One natural sub-module: spio_rr_arbiter. Combinational: NUM_REQ request vector + rr_ptr -> valid flag and winner index.

Test Plan:
- Single read: req[0]=1, addr=CRCE_REG with crce_ctr=5 -> reg_write stays 0; ack[0] in cycle 2; rdata=5.
- Single write: req[1]=1, write=1, addr=IDSO_REG, wdata=16'hA5A5 -> reg_write high exactly one cycle (cycle 1) with the matching addr and data; ack[1] in cycle 2; a subsequent read returns 16'hA5A5.
- Contention: req=2'b11 held for 4 transactions -> acks in order 0,1,0,1, spaced 3 cycles apart.
- Input change after grant: req[0] addr switched to VERS_REG in cycle 1 -> access still targets the originally latched address.
- Reset during ACCESS with write=1 -> all outputs return to reset values immediately; no ack; next request is granted to requester 0.
- (LOCK_EN) Requester 1 locked while req[0] is pending -> requester 1 gets 3 consecutive grants; after its lock=0 access, requester 0 is granted next.

Source files
------------

// File: rtl/spio_hss_multiplexer_reg_arbiter_pkg.sv
// Purpose : shared types and widths for the HSS multiplexer register-port arbiter.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: register address/data widths, FSM state encoding (IDLE=0, ACCESS=1, ACK=2),
//           index-width helper. Optional feature macro used elsewhere: SPIO_HSS_REG_ARB_LOCK_EN.
package spio_hss_multiplexer_reg_arbiter_pkg;

  localparam int REGA_BITS = 8;
  localparam int REGD_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;

  // Width of a requester index; never below 1 so a 1-bit vector is always legal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spio_hss_multiplexer_reg_arbiter_if.sv
// Purpose : bundles requester-side req/ack signals and register-bank access port.
// Latency : n/a (wiring only).
// Backpressure : req is held by the requester until its one-hot ack pulse.
// Modports: slave  = arbiter (consumes requests, drives ack/rdata and the bank port)
//           master = requesters + register bank (drive requests and reg_read_data)
// Macro SPIO_HSS_REG_ARB_LOCK_EN adds req_lock.
interface spio_hss_multiplexer_reg_arbiter_if
  import spio_hss_multiplexer_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REGA_W  = REGA_BITS,
  parameter int REGD_W  = REGD_BITS
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*REGA_W-1:0] req_addr;
  logic [NUM_REQ*REGD_W-1:0] req_wdata;
`ifdef SPIO_HSS_REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic [NUM_REQ-1:0]        ack;
  logic [REGD_W-1:0]         rdata;
  logic                      reg_write;
  logic [REGA_W-1:0]         reg_addr;
  logic [REGD_W-1:0]         reg_write_data;
  logic [REGD_W-1:0]         reg_read_data;

  modport slave (
`ifdef SPIO_HSS_REG_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req, req_write, req_addr, req_wdata, reg_read_data,
    output ack, rdata, reg_write, reg_addr, reg_write_data
  );

  modport master (
`ifdef SPIO_HSS_REG_ARB_LOCK_EN
    output req_lock,
`endif
    output req, req_write, req_addr, req_wdata, reg_read_data,
    input  ack, rdata, reg_write, reg_addr, reg_write_data
  );

endinterface

// File: rtl/spio_hss_multiplexer_reg_arbiter_rr.sv
// Purpose : combinational round-robin pick; first set request above i_ptr, wrapping.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; caller decides when the pick is consumed.
// Ports: i_req request vector, i_ptr last winner, o_vld any request, o_idx winner.
module spio_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_vld,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    int j;
    j     = 0;
    o_vld = 1'b0;
    o_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spio_hss_multiplexer_reg_arbiter.sv
// Purpose : sole driver of the HSS mux register bank port, shared round-robin by NUM_REQ requesters.
// Latency : grant edge -> 1 ACCESS cycle -> ack in the 2nd cycle; one access per 3 cycles.
// Backpressure : requesters hold req (level) until ack; fields are sampled only at the grant edge.
// Ports: clk, rst (async active-high), bus (slave modport: req/ack side + register bank side).
// Macro SPIO_HSS_REG_ARB_LOCK_EN: owner lock for read-modify-write sequences.
module spio_hss_multiplexer_reg_arbiter
  import spio_hss_multiplexer_reg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int REGA_W  = REGA_BITS,
  parameter int REGD_W  = REGD_BITS
) (
  input  logic clk,
  input  logic rst,
  spio_hss_multiplexer_reg_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic               r_wr;
  logic [IDX_W-1:0]   r_winner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [REGA_W-1:0]  r_addr;
  logic [REGD_W-1:0]  r_wdata;
  logic [REGD_W-1:0]  r_rdata;
  logic               w_rr_vld;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_gnt_vld;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_grant;

  spio_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req (bus.req),
    .i_ptr (r_rr_ptr),
    .o_vld (w_rr_vld),
    .o_idx (w_rr_idx)
  );

`ifdef SPIO_HSS_REG_ARB_LOCK_EN
  // r_winner doubles as lock owner. A locked owner whose req is low in IDLE
  // loses the lock in that same cycle, so round-robin decides immediately.
  logic r_locked;
  logic w_lock_hold;
  assign w_lock_hold = r_locked & bus.req[r_winner];
  assign w_gnt_vld   = w_lock_hold | w_rr_vld;
  assign w_gnt_idx   = w_lock_hold ? r_winner : w_rr_idx;
`else
  assign w_gnt_vld   = w_rr_vld;
  assign w_gnt_idx   = w_rr_idx;
`endif

  assign w_grant            = (r_state == ST_IDLE) && w_gnt_vld;
  assign bus.reg_addr       = r_addr;
  assign bus.reg_write_data = r_wdata;
  assign bus.rdata          = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // reg_write and ack are decoded from state so neither can appear outside its cycle.
  always_comb begin
    w_state_nxt   = r_state;
    bus.reg_write = 1'b0;
    bus.ack       = '0;
    case (r_state)
      ST_IDLE:   if (w_gnt_vld) w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        bus.reg_write = r_wr;
        w_state_nxt   = ST_ACK;
      end
      ST_ACK: begin
        bus.ack[r_winner] = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_winner <= '0;
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_winner <= w_gnt_idx;
        r_rr_ptr <= w_gnt_idx;
        r_wr     <= bus.req_write[w_gnt_idx];
        r_addr   <= bus.req_addr[int'(w_gnt_idx)*REGA_W +: REGA_W];
        r_wdata  <= bus.req_wdata[int'(w_gnt_idx)*REGD_W +: REGD_W];
      end
      // Read is taken in the same edge that commits a write, so writes return the old value.
      if (r_state == ST_ACCESS) r_rdata <= bus.reg_read_data;
    end
  end

`ifdef SPIO_HSS_REG_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_locked <= 1'b0;
    else if (r_state == ST_IDLE)    r_locked <= w_gnt_vld ? bus.req_lock[w_gnt_idx] : 1'b0;
  end
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_reg_arbiter.sv
// Purpose : directed bench for the register-port arbiter with a small register bank model.
// Latency : n/a.
// Backpressure : n/a.
module tb_spio_hss_multiplexer_reg_arbiter;
  import spio_hss_multiplexer_reg_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int AW = REGA_BITS;
  localparam int DW = REGD_BITS;
  localparam logic [AW-1:0] VERS_REG = 8'h00;
  localparam logic [AW-1:0] CRCE_REG = 8'h10;
  localparam logic [AW-1:0] IDSO_REG = 8'h20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spio_hss_multiplexer_reg_arbiter_if #(.NUM_REQ(NR), .REGA_W(AW), .REGD_W(DW)) bus ();

  spio_hss_multiplexer_reg_arbiter #(.NUM_REQ(NR), .REGA_W(AW), .REGD_W(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register bank: combinational read, write on clock edge, preset on reset.
  logic [DW-1:0] mem [0:255];
  assign bus.reg_read_data = mem[bus.reg_addr];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[VERS_REG] <= 16'h0102;
      mem[CRCE_REG] <= 16'd5;
      mem[IDSO_REG] <= 16'h1111;
    end else if (bus.reg_write) begin
      mem[bus.reg_addr] <= bus.reg_write_data;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int            win;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [NR-1:0] oh;
    int            w;
    int            seq_win [4];

    // req wr  a0        a1        d0        d1        win rdata
    vt[0] = '{2'b01, 2'b00, CRCE_REG, VERS_REG, 16'h1234, 16'h0000, 0, 16'd5};
    vt[1] = '{2'b10, 2'b10, VERS_REG, IDSO_REG, 16'h0000, 16'hA5A5, 1, 16'h1111};
    vt[2] = '{2'b01, 2'b00, IDSO_REG, VERS_REG, 16'h0000, 16'h0000, 0, 16'hA5A5};
    vt[3] = '{2'b11, 2'b00, VERS_REG, CRCE_REG, 16'h0000, 16'h0000, 1, 16'd5};
    vt[4] = '{2'b11, 2'b00, VERS_REG, CRCE_REG, 16'h0000, 16'h0000, 0, 16'h0102};
    vt[5] = '{2'b10, 2'b10, VERS_REG, CRCE_REG, 16'h0000, 16'h0007, 1, 16'd5};
    vt[6] = '{2'b01, 2'b00, CRCE_REG, VERS_REG, 16'h0000, 16'h0000, 0, 16'd7};
    vt[7] = '{2'b11, 2'b11, VERS_REG, IDSO_REG, 16'hBEEF, 16'h0000, 1, 16'hA5A5};
    vt[8] = '{2'b11, 2'b01, VERS_REG, IDSO_REG, 16'hBEEF, 16'h0000, 0, 16'h0102};

    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef SPIO_HSS_REG_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif

    // Reset values
    #12;
    chk("rst_ack",    32'(bus.ack), 32'd0);
    chk("rst_rdata",  32'(bus.rdata), 32'd0);
    chk("rst_wr",     32'(bus.reg_write), 32'd0);
    chk("rst_addr",   32'(bus.reg_addr), 32'd0);
    chk("rst_wdata",  32'(bus.reg_write_data), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Single-transaction vectors; requests dropped right after grant
    for (int v = 0; v < 9; v++) begin
      bus.req       = vt[v].req;
      bus.req_write = vt[v].wr;
      bus.req_addr  = {vt[v].a1, vt[v].a0};
      bus.req_wdata = {vt[v].d1, vt[v].d0};
      tick();
      chk($sformatf("v%0d_acc_ack", v),   32'(bus.ack), 32'd0);
      chk($sformatf("v%0d_acc_wr", v),    32'(bus.reg_write), 32'(vt[v].wr[vt[v].win]));
      chk($sformatf("v%0d_acc_addr", v),  32'(bus.reg_addr), 32'(vt[v].win ? vt[v].a1 : vt[v].a0));
      chk($sformatf("v%0d_acc_wdata", v), 32'(bus.reg_write_data), 32'(vt[v].win ? vt[v].d1 : vt[v].d0));
      bus.req       = '0;
      bus.req_write = '0;
      bus.req_addr  = '1;
      tick();
      oh = NR'(1) << vt[v].win;
      chk($sformatf("v%0d_ack", v),    32'(bus.ack), 32'(oh));
      chk($sformatf("v%0d_rdata", v),  32'(bus.rdata), 32'(vt[v].exp_rd));
      chk($sformatf("v%0d_ack_wr", v), 32'(bus.reg_write), 32'd0);
      tick();
      chk($sformatf("v%0d_idle_ack", v),  32'(bus.ack), 32'd0);
      chk($sformatf("v%0d_hold_rd", v),   32'(bus.rdata), 32'(vt[v].exp_rd));
    end

    // Reset asserted during a write ACCESS cycle
    bus.req       = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr  = {IDSO_REG, VERS_REG};
    bus.req_wdata = {16'hFFFF, 16'h0000};
    tick();
    chk("mid_wr_before", 32'(bus.reg_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr",    32'(bus.reg_write), 32'd0);
    chk("mid_rst_ack",   32'(bus.ack), 32'd0);
    chk("mid_rst_addr",  32'(bus.reg_addr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.reg_write_data), 32'd0);
    chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    bus.req = '0;
    tick();
    chk("mid_rst_noack1", 32'(bus.ack), 32'd0);
    tick();
    chk("mid_rst_noack2", 32'(bus.ack), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Contention: both requesting continuously, grants 0,1,0,1 every 3 cycles
    bus.req       = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {VERS_REG, CRCE_REG};
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n % 3 == 2) begin
        w  = ((n - 2) / 3) % 2;
        oh = NR'(1) << w;
        chk($sformatf("cont_ack_c%0d", n),   32'(bus.ack), 32'(oh));
        chk($sformatf("cont_rdata_c%0d", n), 32'(bus.rdata), w ? 32'h0102 : 32'd5);
      end else begin
        chk($sformatf("cont_noack_c%0d", n), 32'(bus.ack), 32'd0);
      end
      chk($sformatf("cont_wr_c%0d", n), 32'(bus.reg_write), 32'd0);
      if (n == 11) bus.req = '0;
    end
    tick();
    chk("idle_ack",       32'(bus.ack), 32'd0);
    chk("idle_addr_hold", 32'(bus.reg_addr), 32'(VERS_REG));

    // Requester changes its address after grant
    bus.req      = 2'b01;
    bus.req_addr = {VERS_REG, CRCE_REG};
    tick();
    chk("chg_addr_grant", 32'(bus.reg_addr), 32'(CRCE_REG));
    bus.req_addr = {VERS_REG, VERS_REG};
    bus.req      = '0;
    #1;
    chk("chg_addr_stable", 32'(bus.reg_addr), 32'(CRCE_REG));
    tick();
    chk("chg_ack",   32'(bus.ack), 32'(2'b01));
    chk("chg_rdata", 32'(bus.rdata), 32'd5);
    tick();

`ifdef SPIO_HSS_REG_ARB_LOCK_EN
    // Requester 1 holds a lock for two accesses, releases on the third
    seq_win = '{1, 1, 1, 0};
    bus.req      = 2'b11;
    bus.req_lock = 2'b10;
    bus.req_addr = {VERS_REG, CRCE_REG};
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n % 3 == 2) begin
        oh = NR'(1) << seq_win[(n - 2) / 3];
        chk($sformatf("lock_ack_c%0d", n), 32'(bus.ack), 32'(oh));
      end else begin
        chk($sformatf("lock_noack_c%0d", n), 32'(bus.ack), 32'd0);
      end
      if (n == 4)  bus.req_lock = 2'b00;
      if (n == 11) bus.req = '0;
    end
    tick();
`else
    seq_win = '{0, 0, 0, 0};
    w       = seq_win[0];
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
